// File: rtl/alu_rsv_module.sv
// Reservation station in front of the ALU execute unit.
// Holds up to RSV_DEPTH dispatched micro-ops and tracks source readiness from
// writeback broadcasts. It issues the oldest fully-ready entry by ROB age.
// Ports:
//   clk, rst_n                     clock, synchronous active-low reset
//   i_csr_trap_flush               discard every entry and the incoming dispatch
//   i_exu_{mis,ls}_flush/_rob_id   age-based flush requests and their boundary ids
//   i_dsp_rsv_* / o_rsv_dsp_rdy    dispatch handshake and micro-op fields
//   i_wb_vld/_code/_dat            writeback wakeup broadcast
//   i_exu_rsv_rdy / o_rsv_exu_*    issue handshake and issued micro-op fields
module alu_rsv_module #(
    parameter int unsigned RSV_DEPTH      = 4,
    parameter int unsigned PRF_CODE_WIDTH = 6,
    parameter int unsigned PRF_DATA_WIDTH = 32,
    parameter int unsigned ROB_ID_WIDTH   = 8,
    parameter int unsigned PAYLOAD_WIDTH  = 96
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      i_csr_trap_flush,
    input  logic                      i_exu_mis_flush,
    input  logic [ROB_ID_WIDTH-1:0]   i_exu_mis_rob_id,
    input  logic                      i_exu_ls_flush,
    input  logic [ROB_ID_WIDTH-1:0]   i_exu_ls_rob_id,
    input  logic                      i_dsp_rsv_vld,
    output logic                      o_rsv_dsp_rdy,
    input  logic                      i_dsp_rsv_src1_vld,
    input  logic                      i_dsp_rsv_src1_rdy,
    input  logic [PRF_CODE_WIDTH-1:0] i_dsp_rsv_src1_code,
    input  logic [PRF_DATA_WIDTH-1:0] i_dsp_rsv_src1_dat,
    input  logic                      i_dsp_rsv_src2_vld,
    input  logic                      i_dsp_rsv_src2_rdy,
    input  logic [PRF_CODE_WIDTH-1:0] i_dsp_rsv_src2_code,
    input  logic [PRF_DATA_WIDTH-1:0] i_dsp_rsv_src2_dat,
    input  logic                      i_dsp_rsv_dst_vld,
    input  logic [PRF_CODE_WIDTH-1:0] i_dsp_rsv_dst_code,
    input  logic [ROB_ID_WIDTH-1:0]   i_dsp_rsv_rob_id,
    input  logic [PAYLOAD_WIDTH-1:0]  i_dsp_rsv_payload,
    input  logic                      i_wb_vld,
    input  logic [PRF_CODE_WIDTH-1:0] i_wb_code,
    input  logic [PRF_DATA_WIDTH-1:0] i_wb_dat,
    input  logic                      i_exu_rsv_rdy,
    output logic                      o_rsv_exu_vld,
    output logic                      o_rsv_exu_src1_vld,
    output logic [PRF_DATA_WIDTH-1:0] o_rsv_exu_src1_dat,
    output logic                      o_rsv_exu_src2_vld,
    output logic [PRF_DATA_WIDTH-1:0] o_rsv_exu_src2_dat,
    output logic                      o_rsv_exu_dst_vld,
    output logic [PRF_CODE_WIDTH-1:0] o_rsv_exu_dst_code,
    output logic [ROB_ID_WIDTH-1:0]   o_rsv_exu_rob_id,
    output logic [PAYLOAD_WIDTH-1:0]  o_rsv_exu_payload
);

    localparam int unsigned IDX_W = (RSV_DEPTH > 1) ? $clog2(RSV_DEPTH) : 1;
    localparam int unsigned MSB   = ROB_ID_WIDTH - 1;

    // Entry storage
    logic [RSV_DEPTH-1:0]      ent_vld;
    logic [RSV_DEPTH-1:0]      s1_vld;
    logic [RSV_DEPTH-1:0]      s1_rdy;
    logic [RSV_DEPTH-1:0]      s2_vld;
    logic [RSV_DEPTH-1:0]      s2_rdy;
    logic [RSV_DEPTH-1:0]      dst_vld;
    logic [PRF_CODE_WIDTH-1:0] s1_code  [RSV_DEPTH];
    logic [PRF_CODE_WIDTH-1:0] s2_code  [RSV_DEPTH];
    logic [PRF_DATA_WIDTH-1:0] s1_dat   [RSV_DEPTH];
    logic [PRF_DATA_WIDTH-1:0] s2_dat   [RSV_DEPTH];
    logic [PRF_CODE_WIDTH-1:0] dst_code [RSV_DEPTH];
    logic [ROB_ID_WIDTH-1:0]   ent_rob  [RSV_DEPTH];
    logic [PAYLOAD_WIDTH-1:0]  ent_pay  [RSV_DEPTH];

    logic                      flush_any;
    logic [ROB_ID_WIDTH-1:0]   flush_bnd;
    logic [RSV_DEPTH-1:0]      kill;
    logic                      dsp_kill;
    logic [RSV_DEPTH-1:0]      ent_rdy;
    logic [RSV_DEPTH-1:0]      wake1;
    logic [RSV_DEPTH-1:0]      wake2;
    logic                      sel_found;
    logic [IDX_W-1:0]          sel_idx;
    logic                      free_found;
    logic [IDX_W-1:0]          free_idx;
    logic                      issue_fire;
    logic                      dsp_fire;
    logic                      dsp_hit1;
    logic                      dsp_hit2;

    // Age compare across the wrap bit: true when a is older than b
    function automatic logic is_older(input logic [ROB_ID_WIDTH-1:0] a,
                                      input logic [ROB_ID_WIDTH-1:0] b);
        if (a[MSB] ^ b[MSB]) begin
            return a[MSB-1:0] >= b[MSB-1:0];
        end
        return a[MSB-1:0] < b[MSB-1:0];
    endfunction

    // Flush boundary: the older of the two age-based requests
    always_comb begin
        flush_any = i_exu_mis_flush | i_exu_ls_flush;
        flush_bnd = i_exu_ls_rob_id;
        if (i_exu_mis_flush && i_exu_ls_flush) begin
            flush_bnd = is_older(i_exu_mis_rob_id, i_exu_ls_rob_id) ? i_exu_mis_rob_id
                                                                     : i_exu_ls_rob_id;
        end else if (i_exu_mis_flush) begin
            flush_bnd = i_exu_mis_rob_id;
        end
        dsp_kill = i_csr_trap_flush | (flush_any & is_older(flush_bnd, i_dsp_rsv_rob_id));
    end

    // Per-entry kill, readiness and wakeup match
    always_comb begin
        kill    = '0;
        ent_rdy = '0;
        wake1   = '0;
        wake2   = '0;
        for (int i = 0; i < RSV_DEPTH; i++) begin
            kill[i]    = i_csr_trap_flush | (flush_any & is_older(flush_bnd, ent_rob[i]));
            ent_rdy[i] = ent_vld[i] & s1_rdy[i] & s2_rdy[i];
            wake1[i]   = i_wb_vld & ent_vld[i] & s1_vld[i] & ~s1_rdy[i] & (s1_code[i] == i_wb_code);
            wake2[i]   = i_wb_vld & ent_vld[i] & s2_vld[i] & ~s2_rdy[i] & (s2_code[i] == i_wb_code);
        end
    end

    // Oldest ready entry, and lowest free slot
    always_comb begin
        sel_found  = 1'b0;
        sel_idx    = '0;
        free_found = 1'b0;
        free_idx   = '0;
        for (int i = 0; i < RSV_DEPTH; i++) begin
            if (ent_rdy[i] && (!sel_found || is_older(ent_rob[i], ent_rob[sel_idx]))) begin
                sel_found = 1'b1;
                sel_idx   = IDX_W'(i);
            end
            if (!ent_vld[i] && !free_found) begin
                free_found = 1'b1;
                free_idx   = IDX_W'(i);
            end
        end
    end

    assign o_rsv_dsp_rdy = free_found;
    assign o_rsv_exu_vld = sel_found & ~kill[sel_idx];
    assign issue_fire    = o_rsv_exu_vld & i_exu_rsv_rdy;
    assign dsp_fire      = i_dsp_rsv_vld & free_found & ~dsp_kill;
    assign dsp_hit1      = i_wb_vld & i_dsp_rsv_src1_vld & ~i_dsp_rsv_src1_rdy
                         & (i_dsp_rsv_src1_code == i_wb_code);
    assign dsp_hit2      = i_wb_vld & i_dsp_rsv_src2_vld & ~i_dsp_rsv_src2_rdy
                         & (i_dsp_rsv_src2_code == i_wb_code);

    // Issue bus, zeroed when nothing is ready
    assign o_rsv_exu_src1_vld = sel_found & s1_vld[sel_idx];
    assign o_rsv_exu_src1_dat = sel_found ? s1_dat[sel_idx] : '0;
    assign o_rsv_exu_src2_vld = sel_found & s2_vld[sel_idx];
    assign o_rsv_exu_src2_dat = sel_found ? s2_dat[sel_idx] : '0;
    assign o_rsv_exu_dst_vld  = sel_found & dst_vld[sel_idx];
    assign o_rsv_exu_dst_code = sel_found ? dst_code[sel_idx] : '0;
    assign o_rsv_exu_rob_id   = sel_found ? ent_rob[sel_idx] : '0;
    assign o_rsv_exu_payload  = sel_found ? ent_pay[sel_idx] : '0;

    // Entry update: dispatch into the free slot, otherwise kill/issue/wakeup
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ent_vld <= '0;
            s1_vld  <= '0;
            s1_rdy  <= '0;
            s2_vld  <= '0;
            s2_rdy  <= '0;
            dst_vld <= '0;
            for (int i = 0; i < RSV_DEPTH; i++) begin
                s1_code[i]  <= '0;
                s2_code[i]  <= '0;
                s1_dat[i]   <= '0;
                s2_dat[i]   <= '0;
                dst_code[i] <= '0;
                ent_rob[i]  <= '0;
                ent_pay[i]  <= '0;
            end
        end else begin
            for (int i = 0; i < RSV_DEPTH; i++) begin
                if (dsp_fire && (free_idx == IDX_W'(i))) begin
                    ent_vld[i]  <= 1'b1;
                    s1_vld[i]   <= i_dsp_rsv_src1_vld;
                    s1_rdy[i]   <= ~i_dsp_rsv_src1_vld | i_dsp_rsv_src1_rdy | dsp_hit1;
                    s1_code[i]  <= i_dsp_rsv_src1_code;
                    s1_dat[i]   <= dsp_hit1 ? i_wb_dat : i_dsp_rsv_src1_dat;
                    s2_vld[i]   <= i_dsp_rsv_src2_vld;
                    s2_rdy[i]   <= ~i_dsp_rsv_src2_vld | i_dsp_rsv_src2_rdy | dsp_hit2;
                    s2_code[i]  <= i_dsp_rsv_src2_code;
                    s2_dat[i]   <= dsp_hit2 ? i_wb_dat : i_dsp_rsv_src2_dat;
                    dst_vld[i]  <= i_dsp_rsv_dst_vld;
                    dst_code[i] <= i_dsp_rsv_dst_code;
                    ent_rob[i]  <= i_dsp_rsv_rob_id;
                    ent_pay[i]  <= i_dsp_rsv_payload;
                end else begin
                    if (kill[i] || (issue_fire && (sel_idx == IDX_W'(i)))) begin
                        ent_vld[i] <= 1'b0;
                    end
                    if (wake1[i]) begin
                        s1_rdy[i] <= 1'b1;
                        s1_dat[i] <= i_wb_dat;
                    end
                    if (wake2[i]) begin
                        s2_rdy[i] <= 1'b1;
                        s2_dat[i] <= i_wb_dat;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_alu_rsv_module.sv
// Self-checking bench for alu_rsv_module: directed scenarios plus a random run
// compared against a queue-based reference model of the station.
module tb_alu_rsv_module;

    localparam int unsigned DEPTH = 4;

    logic        clk;
    logic        rst_n;
    logic        trap;
    logic        mis_flush;
    logic [7:0]  mis_id;
    logic        ls_flush;
    logic [7:0]  ls_id;
    logic        dsp_vld;
    logic        dsp_rdy;
    logic        s1v, s1r, s2v, s2r;
    logic [5:0]  s1c, s2c;
    logic [31:0] s1d, s2d;
    logic        dstv;
    logic [5:0]  dstc;
    logic [7:0]  rob;
    logic [95:0] pay;
    logic        wb_vld;
    logic [5:0]  wb_code;
    logic [31:0] wb_dat;
    logic        exu_rdy;
    logic        o_vld;
    logic        o_s1v, o_s2v, o_dv;
    logic [31:0] o_s1d, o_s2d;
    logic [5:0]  o_dc;
    logic [7:0]  o_rob;
    logic [95:0] o_pay;

    alu_rsv_module dut (
        .clk                 (clk),
        .rst_n               (rst_n),
        .i_csr_trap_flush    (trap),
        .i_exu_mis_flush     (mis_flush),
        .i_exu_mis_rob_id    (mis_id),
        .i_exu_ls_flush      (ls_flush),
        .i_exu_ls_rob_id     (ls_id),
        .i_dsp_rsv_vld       (dsp_vld),
        .o_rsv_dsp_rdy       (dsp_rdy),
        .i_dsp_rsv_src1_vld  (s1v),
        .i_dsp_rsv_src1_rdy  (s1r),
        .i_dsp_rsv_src1_code (s1c),
        .i_dsp_rsv_src1_dat  (s1d),
        .i_dsp_rsv_src2_vld  (s2v),
        .i_dsp_rsv_src2_rdy  (s2r),
        .i_dsp_rsv_src2_code (s2c),
        .i_dsp_rsv_src2_dat  (s2d),
        .i_dsp_rsv_dst_vld   (dstv),
        .i_dsp_rsv_dst_code  (dstc),
        .i_dsp_rsv_rob_id    (rob),
        .i_dsp_rsv_payload   (pay),
        .i_wb_vld            (wb_vld),
        .i_wb_code           (wb_code),
        .i_wb_dat            (wb_dat),
        .i_exu_rsv_rdy       (exu_rdy),
        .o_rsv_exu_vld       (o_vld),
        .o_rsv_exu_src1_vld  (o_s1v),
        .o_rsv_exu_src1_dat  (o_s1d),
        .o_rsv_exu_src2_vld  (o_s2v),
        .o_rsv_exu_src2_dat  (o_s2d),
        .o_rsv_exu_dst_vld   (o_dv),
        .o_rsv_exu_dst_code  (o_dc),
        .o_rsv_exu_rob_id    (o_rob),
        .o_rsv_exu_payload   (o_pay)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference model: unordered collection of live micro-ops
    typedef struct {
        logic [7:0]  rob;
        logic        s1v, s1r, s2v, s2r, dv;
        logic [5:0]  s1c, s2c, dc;
        logic [31:0] s1d, s2d;
        logic [95:0] pay;
    } ent_t;

    ent_t         q[$];
    int           m_sel;
    logic         exp_rdy;
    logic         exp_vld;
    logic [176:0] exp_bus;
    logic [176:0] got_bus;

    function automatic bit m_older(logic [7:0] a, logic [7:0] b);
        int ia = int'(a % 128);
        int ib = int'(b % 128);
        if ((a >= 128) != (b >= 128)) return ia >= ib;
        return ia < ib;
    endfunction

    function automatic bit m_kill(logic [7:0] id);
        logic [7:0] bnd;
        if (trap) return 1'b1;
        if (!mis_flush && !ls_flush) return 1'b0;
        if (mis_flush && ls_flush) bnd = m_older(mis_id, ls_id) ? mis_id : ls_id;
        else bnd = mis_flush ? mis_id : ls_id;
        return m_older(bnd, id);
    endfunction

    // Expected outputs for the current cycle from model state and inputs
    task automatic eval_model();
        m_sel   = -1;
        exp_rdy = (q.size() < DEPTH);
        for (int i = 0; i < q.size(); i++) begin
            if (q[i].s1r && q[i].s2r && (m_sel < 0 || m_older(q[i].rob, q[m_sel].rob))) m_sel = i;
        end
        exp_vld = (m_sel >= 0) && !m_kill(q[m_sel].rob);
        exp_bus = '0;
        if (m_sel >= 0)
            exp_bus = {q[m_sel].rob, q[m_sel].s1v, q[m_sel].s1d, q[m_sel].s2v, q[m_sel].s2d,
                       q[m_sel].dv, q[m_sel].dc, q[m_sel].pay};
        got_bus = {o_rob, o_s1v, o_s1d, o_s2v, o_s2d, o_dv, o_dc, o_pay};
    endtask

    // Advance the model by one clock using current inputs
    task automatic commit_model();
        ent_t nq[$];
        ent_t e;
        if (!rst_n) begin
            q.delete();
            return;
        end
        for (int i = 0; i < q.size(); i++) begin
            e = q[i];
            if (m_kill(e.rob)) continue;
            if (exp_vld && exu_rdy && i == m_sel) continue;
            if (wb_vld && !e.s1r && e.s1c == wb_code) begin e.s1r = 1'b1; e.s1d = wb_dat; end
            if (wb_vld && !e.s2r && e.s2c == wb_code) begin e.s2r = 1'b1; e.s2d = wb_dat; end
            nq.push_back(e);
        end
        if (dsp_vld && exp_rdy && !m_kill(rob)) begin
            e.rob = rob; e.s1v = s1v; e.s1c = s1c; e.s1d = s1d;
            e.s2v = s2v; e.s2c = s2c; e.s2d = s2d; e.dv = dstv; e.dc = dstc; e.pay = pay;
            e.s1r = !s1v || s1r;
            e.s2r = !s2v || s2r;
            if (wb_vld && !e.s1r && s1c == wb_code) begin e.s1r = 1'b1; e.s1d = wb_dat; end
            if (wb_vld && !e.s2r && s2c == wb_code) begin e.s2r = 1'b1; e.s2d = wb_dat; end
            nq.push_back(e);
        end
        q = nq;
    endtask

    task automatic idle();
        trap = 0; mis_flush = 0; mis_id = 0; ls_flush = 0; ls_id = 0;
        dsp_vld = 0; s1v = 0; s1r = 0; s1c = 0; s1d = 0; s2v = 0; s2r = 0; s2c = 0; s2d = 0;
        dstv = 0; dstc = 0; rob = 0; pay = 0;
        wb_vld = 0; wb_code = 0; wb_dat = 0; exu_rdy = 0;
    endtask

    task automatic dsp(input logic [7:0] id,
                       input logic v1, input logic r1, input logic [5:0] c1, input logic [31:0] d1,
                       input logic v2, input logic r2, input logic [5:0] c2, input logic [31:0] d2);
        dsp_vld = 1; rob = id;
        s1v = v1; s1r = r1; s1c = c1; s1d = d1;
        s2v = v2; s2r = r2; s2c = c2; s2d = d2;
        dstv = 1; dstc = id[5:0];
        pay = {id, 24'(0), 32'($urandom), 32'($urandom)};
    endtask

    task automatic tick();
        commit_model();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset(input string nm);
        idle();
        rst_n = 0;
        dsp(8'h99, 0, 0, 0, 0, 0, 0, 0, 0);
        exu_rdy = 1;
        trap = 1;
        tick();
        tick();
        rst_n = 1;
        idle();
        #1;
        total++; if (dsp_rdy !== 1'b1) begin bad++; $display("FAIL %s dsp_rdy got %b exp 1", nm, dsp_rdy); end
        total++; if (o_vld !== 1'b0) begin bad++; $display("FAIL %s exu_vld got %b exp 0", nm, o_vld); end
        got_bus = {o_rob, o_s1v, o_s1d, o_s2v, o_s2d, o_dv, o_dc, o_pay};
        total++; if (got_bus !== '0) begin bad++; $display("FAIL %s outputs got %h exp 0", nm, got_bus); end
        tick();
    endtask

    task automatic test_single_issue();
        for (int c = 0; c < 3; c++) begin
            idle();
            exu_rdy = 1;
            if (c == 0) dsp(8'h05, 1, 1, 6'd1, 32'h1111_0001, 1, 1, 6'd2, 32'h2222_0002);
            #1; eval_model();
            total++; if (dsp_rdy !== exp_rdy) begin bad++; $display("FAIL single c%0d dsp_rdy got %b exp %b", c, dsp_rdy, exp_rdy); end
            total++; if (o_vld !== exp_vld) begin bad++; $display("FAIL single c%0d exu_vld got %b exp %b", c, o_vld, exp_vld); end
            if (exp_vld) begin total++; if (got_bus !== exp_bus) begin bad++; $display("FAIL single c%0d bus got %h exp %h", c, got_bus, exp_bus); end end
            if (c == 1) begin total++; if (o_vld !== 1'b1 || o_rob !== 8'h05) begin bad++; $display("FAIL single_rob got vld=%b rob=%h exp vld=1 rob=05", o_vld, o_rob); end end
            if (c == 2) begin total++; if (o_vld !== 1'b0) begin bad++; $display("FAIL single_freed got vld=%b exp 0", o_vld); end end
            tick();
        end
    endtask

    task automatic test_wakeup();
        for (int c = 0; c < 5; c++) begin
            idle();
            exu_rdy = 1;
            if (c == 0) dsp(8'h10, 1, 0, 6'd7, 32'h0, 0, 0, 6'd0, 32'h0);
            if (c == 2) begin wb_vld = 1; wb_code = 6'd7; wb_dat = 32'hDEADBEEF; end
            #1; eval_model();
            total++; if (dsp_rdy !== exp_rdy) begin bad++; $display("FAIL wakeup c%0d dsp_rdy got %b exp %b", c, dsp_rdy, exp_rdy); end
            total++; if (o_vld !== exp_vld) begin bad++; $display("FAIL wakeup c%0d exu_vld got %b exp %b", c, o_vld, exp_vld); end
            if (exp_vld) begin total++; if (got_bus !== exp_bus) begin bad++; $display("FAIL wakeup c%0d bus got %h exp %h", c, got_bus, exp_bus); end end
            if (c == 2) begin total++; if (o_vld !== 1'b0) begin bad++; $display("FAIL wakeup_nobypass got vld=%b exp 0", o_vld); end end
            if (c == 3) begin total++; if (o_vld !== 1'b1 || o_s1d !== 32'hDEADBEEF) begin bad++; $display("FAIL wakeup_issue got vld=%b dat=%h exp vld=1 dat=deadbeef", o_vld, o_s1d); end end
            tick();
        end
    endtask

    task automatic test_full_order();
        logic [7:0] ids [4];
        logic [7:0] order [4];
        ids[0] = 8'h80; ids[1] = 8'h7E; ids[2] = 8'h81; ids[3] = 8'h7F;
        order[0] = 8'h7E; order[1] = 8'h7F; order[2] = 8'h80; order[3] = 8'h81;
        for (int c = 0; c < 10; c++) begin
            idle();
            if (c < 4) dsp(ids[c], 1, 1, 6'd3, 32'(c), 1, 1, 6'd4, 32'(c + 16));
            if (c == 4) dsp(8'h90, 1, 1, 6'd3, 32'h5, 0, 0, 6'd0, 32'h0);
            exu_rdy = (c >= 5);
            #1; eval_model();
            total++; if (dsp_rdy !== exp_rdy) begin bad++; $display("FAIL full c%0d dsp_rdy got %b exp %b", c, dsp_rdy, exp_rdy); end
            total++; if (o_vld !== exp_vld) begin bad++; $display("FAIL full c%0d exu_vld got %b exp %b", c, o_vld, exp_vld); end
            if (exp_vld) begin total++; if (got_bus !== exp_bus) begin bad++; $display("FAIL full c%0d bus got %h exp %h", c, got_bus, exp_bus); end end
            if (c == 4 || c == 5) begin total++; if (dsp_rdy !== 1'b0) begin bad++; $display("FAIL full_rdy c%0d got %b exp 0", c, dsp_rdy); end end
            if (c >= 5 && c <= 8) begin total++; if (o_vld !== 1'b1 || o_rob !== order[c-5]) begin bad++; $display("FAIL full_order c%0d got vld=%b rob=%h exp rob=%h", c, o_vld, o_rob, order[c-5]); end end
            if (c == 9) begin total++; if (o_vld !== 1'b0 || dsp_rdy !== 1'b1) begin bad++; $display("FAIL full_drain got vld=%b rdy=%b exp 0/1", o_vld, dsp_rdy); end end
            tick();
        end
    endtask

    task automatic test_age_flush();
        for (int c = 0; c < 6; c++) begin
            idle();
            if (c < 3) dsp(8'h20 + 8'(2 * c), 1, 1, 6'd5, 32'(c + 100), 0, 0, 6'd0, 32'h0);
            if (c == 3) begin mis_flush = 1; mis_id = 8'h21; ls_flush = 1; ls_id = 8'h23; end
            exu_rdy = (c >= 4);
            #1; eval_model();
            total++; if (dsp_rdy !== exp_rdy) begin bad++; $display("FAIL flush c%0d dsp_rdy got %b exp %b", c, dsp_rdy, exp_rdy); end
            total++; if (o_vld !== exp_vld) begin bad++; $display("FAIL flush c%0d exu_vld got %b exp %b", c, o_vld, exp_vld); end
            if (exp_vld) begin total++; if (got_bus !== exp_bus) begin bad++; $display("FAIL flush c%0d bus got %h exp %h", c, got_bus, exp_bus); end end
            if (c == 4) begin total++; if (o_vld !== 1'b1 || o_rob !== 8'h20) begin bad++; $display("FAIL flush_keep got vld=%b rob=%h exp rob=20", o_vld, o_rob); end end
            if (c == 5) begin total++; if (o_vld !== 1'b0 || dsp_rdy !== 1'b1) begin bad++; $display("FAIL flush_empty got vld=%b rdy=%b exp 0/1", o_vld, dsp_rdy); end end
            tick();
        end
    endtask

    task automatic test_trap();
        for (int c = 0; c < 3; c++) begin
            idle();
            if (c == 0) dsp(8'h30, 1, 1, 6'd1, 32'h30, 1, 1, 6'd2, 32'h31);
            if (c == 1) begin
                dsp(8'h31, 1, 1, 6'd1, 32'h40, 1, 1, 6'd2, 32'h41);
                trap = 1;
                exu_rdy = 1;
            end
            if (c == 2) exu_rdy = 1;
            #1; eval_model();
            total++; if (dsp_rdy !== exp_rdy) begin bad++; $display("FAIL trap c%0d dsp_rdy got %b exp %b", c, dsp_rdy, exp_rdy); end
            total++; if (o_vld !== exp_vld) begin bad++; $display("FAIL trap c%0d exu_vld got %b exp %b", c, o_vld, exp_vld); end
            if (c >= 1) begin total++; if (o_vld !== 1'b0) begin bad++; $display("FAIL trap_noissue c%0d got vld=%b exp 0", c, o_vld); end end
            if (c == 2) begin total++; if (dsp_rdy !== 1'b1) begin bad++; $display("FAIL trap_rdy got %b exp 1", dsp_rdy); end end
            tick();
        end
    endtask

    task automatic test_dsp_wakeup();
        for (int c = 0; c < 3; c++) begin
            idle();
            exu_rdy = 1;
            if (c == 0) begin
                dsp(8'h40, 1, 0, 6'd12, 32'h0, 1, 1, 6'd13, 32'h5);
                wb_vld = 1; wb_code = 6'd12; wb_dat = 32'hCAFEF00D;
            end
            #1; eval_model();
            total++; if (dsp_rdy !== exp_rdy) begin bad++; $display("FAIL dspwake c%0d dsp_rdy got %b exp %b", c, dsp_rdy, exp_rdy); end
            total++; if (o_vld !== exp_vld) begin bad++; $display("FAIL dspwake c%0d exu_vld got %b exp %b", c, o_vld, exp_vld); end
            if (exp_vld) begin total++; if (got_bus !== exp_bus) begin bad++; $display("FAIL dspwake c%0d bus got %h exp %h", c, got_bus, exp_bus); end end
            if (c == 1) begin total++; if (o_vld !== 1'b1 || o_s1d !== 32'hCAFEF00D) begin bad++; $display("FAIL dspwake_dat got vld=%b dat=%h exp 1/cafef00d", o_vld, o_s1d); end end
            tick();
        end
    endtask

    task automatic test_random();
        logic [7:0] nrob = 8'hF0;
        for (int c = 0; c < 600; c++) begin
            idle();
            if ($urandom_range(99) < 60) begin
                dsp(nrob, 1'($urandom), 1'($urandom), 6'($urandom_range(7)), $urandom,
                          1'($urandom), 1'($urandom), 6'($urandom_range(7)), $urandom);
                nrob = nrob + 8'($urandom_range(1, 2));
            end
            if ($urandom_range(99) < 80) begin
                wb_vld = 1; wb_code = 6'($urandom_range(7)); wb_dat = $urandom;
            end
            exu_rdy = ($urandom_range(99) < 70);
            if ($urandom_range(99) < 5) begin mis_flush = 1; mis_id = nrob - 8'($urandom_range(1, 5)); end
            if ($urandom_range(99) < 5) begin ls_flush = 1; ls_id = nrob - 8'($urandom_range(1, 5)); end
            if ($urandom_range(99) < 2) trap = 1;
            #1; eval_model();
            total++; if (dsp_rdy !== exp_rdy) begin bad++; $display("FAIL random c%0d dsp_rdy got %b exp %b", c, dsp_rdy, exp_rdy); end
            total++; if (o_vld !== exp_vld) begin bad++; $display("FAIL random c%0d exu_vld got %b exp %b", c, o_vld, exp_vld); end
            if (exp_vld) begin total++; if (got_bus !== exp_bus) begin bad++; $display("FAIL random c%0d bus got %h exp %h", c, got_bus, exp_bus); end end
            tick();
        end
    endtask

    initial begin
        idle();
        rst_n = 0;
        @(posedge clk);
        #1;
        test_reset("reset");
        test_single_issue();
        test_wakeup();
        test_full_order();
        test_age_flush();
        test_trap();
        test_dsp_wakeup();
        test_random();
        test_reset("reset_mid");
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
